mult_req_ctrl: RTL

Requester-side sequencer for the 8x8 sequential multiplier. Accepts operand pairs over a valid/ready handshake, drives the multiplier's `start`/`dataa`/`datab` inputs with the one-cycle start pulse its control FSM expects, waits for `done_flag`, and captures the 16-bit product into a result register with its own valid/ready handshake. Guarantees the multiplier never sees `start` while a calculation is in flight. Detects lost or spurious completions.

---
 rtl/mult_req_pkg.sv | 17 +
 rtl/mult_req_timer.sv | 29 ++
 rtl/mult_req_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mult_req_pkg.sv
// Shared types and constants for the 8x8 multiplier requester (mult_req_ctrl).
package mult_req_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_SPURIOUS = 1;

    // Edges from the rising edge of start to the rising edge of done_flag.
    localparam int MULT_LATENCY = 5;

endpackage

// File: rtl/mult_req_timer.sv
// Loadable up-counter for the WAIT timeout; tc flags the edge on which the
// count would reach TIMEOUT.
module mult_req_timer #(
    parameter int unsigned TIMEOUT = 12
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [7:0] r_cnt;
    logic [8:0] w_cnt_nxt;

    assign w_cnt_nxt = {1'b0, r_cnt} + 9'd1;
    assign tc        = en && (w_cnt_nxt == 9'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_cnt_nxt[7:0];
        end
    end

endmodule

// File: rtl/mult_req_ctrl.sv
// Requester-side sequencer for the 8x8 sequential multiplier.
// Optional build macro MULT_REQ_RETRY_EN: re-launch on timeout up to MAX_RETRY times.
//
// state     | meaning
// ST_IDLE   | ready for an operand pair
// ST_LAUNCH | start pulse out, timeout counter cleared
// ST_WAIT   | waiting for done_flag or timeout
// ST_HOLD   | product held until the consumer accepts it
module mult_req_ctrl
    import mult_req_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 12,
    parameter int unsigned MAX_RETRY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        start,
    output logic [7:0]  dataa,
    output logic [7:0]  datab,
    input  logic        done_flag,
    input  logic [15:0] product8x8,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_product,
    output logic        busy,
    output logic [1:0]  err,
    input  logic        err_clr
);

    state_t      r_state;
    state_t      w_next;
    logic        r_start;
    logic [7:0]  r_dataa;
    logic [7:0]  r_datab;
    logic        r_res_valid;
    logic [15:0] r_res_product;
    logic [1:0]  r_err;

    logic        w_accept;
    logic        w_capture;
    logic        w_res_ack;
    logic        w_tmr_clr;
    logic        w_tmr_en;
    logic        w_tc;
    logic [1:0]  w_err_set;

`ifdef MULT_REQ_RETRY_EN
    logic [7:0]  r_retry;
    logic        w_retry;
`else
    logic        w_unused_max_retry;
    assign w_unused_max_retry = (MAX_RETRY != 0);
`endif

    mult_req_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_tmr_clr),
        .en      (w_tmr_en),
        .tc      (w_tc)
    );

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_res_ack = 1'b0;
        w_tmr_clr = 1'b0;
        w_tmr_en  = 1'b0;
        w_err_set = '0;
`ifdef MULT_REQ_RETRY_EN
        w_retry   = 1'b0;
`endif
        // Completions outside WAIT are flagged and otherwise ignored.
        w_err_set[ERR_SPURIOUS] = done_flag && (r_state != ST_WAIT);

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_tmr_clr = 1'b1;
                w_next    = ST_WAIT;
            end
            ST_WAIT: begin
                w_tmr_en = 1'b1;
                // done_flag takes priority over a coincident terminal count.
                if (done_flag) begin
                    w_capture = 1'b1;
                    w_next    = ST_HOLD;
                end else if (w_tc) begin
`ifdef MULT_REQ_RETRY_EN
                    if (32'(r_retry) < MAX_RETRY) begin
                        w_retry = 1'b1;
                        w_next  = ST_LAUNCH;
                    end else begin
                        w_err_set[ERR_TIMEOUT] = 1'b1;
                        w_next                 = ST_IDLE;
                    end
`else
                    w_err_set[ERR_TIMEOUT] = 1'b1;
                    w_next                 = ST_IDLE;
`endif
                end
            end
            ST_HOLD: begin
                if (r_res_valid && res_ready) begin
                    w_res_ack = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_start       <= 1'b0;
            r_dataa       <= '0;
            r_datab       <= '0;
            r_res_valid   <= 1'b0;
            r_res_product <= '0;
            r_err         <= '0;
        end else begin
            r_state <= w_next;
            // LAUNCH never follows itself, so this is always a single-cycle pulse.
            r_start <= (w_next == ST_LAUNCH);
            if (w_accept) begin
                r_dataa <= in_a;
                r_datab <= in_b;
            end
            if (w_capture) begin
                r_res_product <= product8x8;
                r_res_valid   <= 1'b1;
            end else if (w_res_ack) begin
                r_res_valid <= 1'b0;
            end
            r_err <= (err_clr ? 2'b00 : r_err) | w_err_set;
        end
    end

`ifdef MULT_REQ_RETRY_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_retry <= '0;
        end else if (w_accept) begin
            r_retry <= '0;
        end else if (w_retry) begin
            r_retry <= r_retry + 8'd1;
        end
    end
`endif

    assign in_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign start       = r_start;
    assign dataa       = r_dataa;
    assign datab       = r_datab;
    assign res_valid   = r_res_valid;
    assign res_product = r_res_product;
    assign err         = r_err;

endmodule
